seg_scan_mux: RTL
=================

# seg_scan_mux

Parametrised, time-multiplexed seven-segment display driver. Holds NUM_DIGITS 4-bit digit codes and selects one per scan slot through an internal N-to-1 multiplexer. It decodes the selected code to active-low segments and drives one active-low anode at a time, with a blanking cycle between digits to prevent ghosting. It sits between the datapath and the board's common-anode display and replaces per-digit static decode.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- CLK_DIV, 100000, clk cycles each digit is driven per slot; must be at least 1.

Ports:
- clk, input, 1, sole clock; all flops are rising-edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, scan enable; low blanks the display and restarts the scan.
- digits, input, 4*NUM_DIGITS, digit codes; digit k is digits[4k+3:4k], and digit 0 is rightmost.
- dp_in, input, NUM_DIGITS, decimal point request per digit; 1 = lit.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1, decimal point, active-low.
- an, output, NUM_DIGITS, anode enables, active-low, at most one low.
- frame_start, output, 1, one-cycle pulse in each LOAD cycle.

## Operation
- **States:** LOAD, DRIVE, BLANK.
  - LOAD: snapshot digits and dp_in into the frame buffer, set idx=0, then go to DRIVE.
  - DRIVE: an[idx]=0, seg=glyph(buf[idx]), dp=~dp_buf[idx]. The prescaler counts 0..CLK_DIV-1. When it reaches CLK_DIV-1:
    - if idx < NUM_DIGITS-1, go to BLANK;
    - otherwise go to LOAD.
  - BLANK: an all 1, seg=7'h7F, dp=1, idx increments, then go to DRIVE.
- **Frame buffer:** inputs are sampled only in LOAD. Input changes mid-frame do not appear until the next frame, so no tearing.
- **Glyphs (0 = lit):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 are set by Configuration.
- **en low:** every cycle is forced to LOAD-equivalent outputs (an all 1, seg 7'h7F, dp 1, frame_start 0), with idx=0 and prescaler=0. The frame buffer is not updated.
  - On the first cycle with en high, the state is LOAD with normal snapshot and frame_start=1.
- **Prescaler:** width $clog2(CLK_DIV+1); it is reset to 0 on every entry to DRIVE.
- **idx:** width $clog2(NUM_DIGITS). It never exceeds NUM_DIGITS-1; wrap-around happens only through LOAD.

## Timing
- **Registered outputs:** all outputs are flops computed from next-state logic, so they reflect the state occupied in the same cycle.
- **Reset values:** seg=7'h7F, dp=1, an all 1, frame_start=0, state=LOAD, idx=0, prescaler=0, frame buffer all 0.
- **After rst falls:** the first cycle is LOAD, with frame_start=1 if en=1. Digit 0 lights in the next cycle.
- **Slot length:** each digit slot is 1 dead cycle (BLANK or LOAD) followed by CLK_DIV drive cycles.
- **Frame period:** NUM_DIGITS*(CLK_DIV+1) cycles. frame_start pulses exactly once per period.
- **Snapshot latency:** a value on digits at the LOAD edge is displayed on digit k starting 1 + k*(CLK_DIV+1) cycles later.
- **rst precedence:** rst overrides en. rst mid-DRIVE blanks all outputs on the next edge.
- **Simultaneous en=0 and prescaler terminal count:** en wins.

## Configuration
- SEG_SCAN_HEX_EN
  - **Defined:** codes 10..15 display A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - **Undefined:** codes 10..15 display blank (7'h7F). dp is unaffected in both cases.

## Structure
- **Package seg_pkg:**
  - state enum (LOAD, DRIVE, BLANK);
  - SEG_BLANK=7'h7F;
  - the sixteen glyph constants.
- **Sub-module seg_glyph:** purely combinational 4-bit code to 7-bit glyph decode, with the SEG_SCAN_HEX_EN ifdef local to it.
- **Top level:** holds the FSM, prescaler, idx, frame buffer and output registers.

## Test plan
- **Reset and first frame:** NUM_DIGITS=4, CLK_DIV=3, digits=16'h4321, dp_in=0.
  - During rst: an=1111, seg=7F.
  - Then LOAD with frame_start=1, then an=1110 with seg=1111001 (digit "1") for 3 cycles.
  - Then 1 blank cycle, then an=1101 with seg=0100100 (digit "2"). Period is 16 cycles.
- **Mid-frame change:** set digits to 16'h9999 while idx=1.
  - Digits 2 and 3 still show "3" and "4".
  - "9" (seg 0010000) appears from the next LOAD.
- **Codes 10..15:** digits=16'hFEDC.
  - Without the macro, all four slots give seg=7F.
  - With SEG_SCAN_HEX_EN, slot 0 gives seg=1000110 ("C").
- **en deasserted mid-DRIVE:**
  - The next cycle gives an=1111, seg=7F.
  - On reassert, one LOAD cycle with frame_start=1, then digit 0.
- **CLK_DIV=1, NUM_DIGITS=8:**
  - an walks a single 0 with a dead cycle between digits.
  - frame_start repeats every 16 cycles; never more than one an bit is low.
- **dp:** dp_in=4'b0100.
  - dp=0 only while an=1011; dp=1 during every dead cycle.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// seg_pkg: scan FSM states and active-low {g,f,e,d,c,b,a} glyph constants for seg_scan_mux
package seg_pkg;
  typedef enum logic [1:0] {LOAD, DRIVE, BLANK} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: datapath-side inputs and display-side outputs of the scanner
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  logic frame_start;
  modport master (output en, digits, dp_in, input seg, dp, an, frame_start);
  modport slave (input en, digits, dp_in, output seg, dp, an, frame_start);
endinterface

// File: rtl/seg_scan_mux_glyph.sv
// seg_glyph: 4-bit code to active-low glyph; SEG_SCAN_HEX_EN shows A-F for codes 10-15,
// otherwise those codes are blank
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_glyph
);
`ifdef SEG_SCAN_HEX_EN
  assign o_glyph = GLYPH[i_code];
`else
  assign o_glyph = (i_code > 4'd9) ? SEG_BLANK : GLYPH[i_code];
`endif
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed common-anode seven-segment scanner with a blank cycle between digits
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg_scan_mux_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_buf;
  logic [NUM_DIGITS-1:0] r_dp_buf;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0] r_seg;
  logic r_dp;
  logic r_fs;
  logic [IW-1:0] w_idx_n;
  logic [3:0] w_code;
  logic [6:0] w_glyph;
  logic w_term;
  logic w_to_load;
  logic w_to_drive;
  logic w_to_blank;
  assign w_term = (r_state == DRIVE) && (r_cnt == CNT_MAX);
  // An idle LOAD (after reset or en low) has frame_start low and must first perform the real LOAD
  assign w_to_load = ((r_state == LOAD) && !r_fs) || (w_term && (r_idx == IDX_MAX));
  assign w_to_drive = ((r_state == LOAD) && r_fs) || (r_state == BLANK);
  assign w_to_blank = w_term && (r_idx != IDX_MAX);
  assign w_idx_n = (r_state == BLANK) ? r_idx + 1'b1 : r_idx;
  assign w_code = r_buf[{w_idx_n, 2'b00} +: 4];
  seg_glyph u_glyph (
    .i_code (w_code),
    .o_glyph(w_glyph)
  );
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_cnt <= '0;
      r_an <= '1;
      r_seg <= SEG_BLANK;
      r_dp <= 1'b1;
      r_fs <= 1'b0;
      if (rst) begin
        r_buf <= '0;
        r_dp_buf <= '0;
      end
    end else begin
      r_fs <= w_to_load;
      if (w_to_load) begin
        r_state <= LOAD;
        r_idx <= '0;
        r_buf <= bus.digits;
        r_dp_buf <= bus.dp_in;
      end
      if (w_to_blank) r_state <= BLANK;
      if (w_to_load || w_to_blank) begin
        r_an <= '1;
        r_seg <= SEG_BLANK;
        r_dp <= 1'b1;
      end
      if (w_to_drive) begin
        r_state <= DRIVE;
        r_idx <= w_idx_n;
        r_cnt <= '0;
        r_an <= ~(NUM_DIGITS'(1) << w_idx_n);
        r_seg <= w_glyph;
        r_dp <= ~r_dp_buf[w_idx_n];
      end else if (r_state == DRIVE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.an = r_an;
  assign bus.seg = r_seg;
  assign bus.dp = r_dp;
  assign bus.frame_start = r_fs;
endmodule
